// File: rtl/lc3b_types.sv
// Shared LC-3b types: cache line, line address and instruction-cache FSM state.
package lc3b_types;

   localparam int LINE_W      = 128;
   localparam int LINE_ADDR_W = 12;

   typedef logic [LINE_W-1:0]      lc3b_line;
   typedef logic [LINE_ADDR_W-1:0] lc3b_line_addr;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } icache_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all ones.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // Increment on inc unless already saturated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache. Hits answer combinationally;
// a miss fetches one whole line over the memory wishbone master.
module icache_dm
   import lc3b_types::*;
#(
   parameter int INDEX_BITS = 3,
   parameter int ADDR_BITS  = 12,
   parameter int LINE_BITS  = 128,
   parameter int CNT_BITS   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cpu_cyc,
   input  logic                   cpu_stb,
   input  logic                   cpu_we,
   input  logic [ADDR_BITS-1:0]   cpu_adr,
   output logic [LINE_BITS-1:0]   cpu_dat_s,
   output logic                   cpu_ack,
   output logic                   cpu_err,
   output logic                   mem_cyc,
   output logic                   mem_stb,
   output logic                   mem_we,
   output logic [LINE_BITS/8-1:0] mem_sel,
   output logic [ADDR_BITS-1:0]   mem_adr,
   input  logic [LINE_BITS-1:0]   mem_dat_s,
   input  logic                   mem_ack,
   input  logic                   flush,
   output logic [CNT_BITS-1:0]    hit_count,
   output logic [CNT_BITS-1:0]    miss_count
);

   localparam int NLINES   = 1 << INDEX_BITS;
   localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;

   icache_state_t state, state_nxt;

   logic [LINE_BITS-1:0] data_arr [NLINES];
   logic [TAG_BITS-1:0]  tag_arr  [NLINES];
   logic [NLINES-1:0]    valid;
   logic [ADDR_BITS-1:0] fill_adr;

   logic [INDEX_BITS-1:0] index, fill_index;
   logic [TAG_BITS-1:0]   tag, fill_tag;
   logic req, wreq, hit;
   logic hit_inc, miss_inc, fill_done, start_fill;

   assign index      = cpu_adr[INDEX_BITS-1:0];
   assign tag        = cpu_adr[ADDR_BITS-1:INDEX_BITS];
   assign fill_index = fill_adr[INDEX_BITS-1:0];
   assign fill_tag   = fill_adr[ADDR_BITS-1:INDEX_BITS];

   assign req  = cpu_cyc & cpu_stb & ~cpu_we;
   assign wreq = cpu_cyc & cpu_stb & cpu_we;
   // A flush in flight makes every lookup miss, even on a line it is clearing.
   assign hit  = valid[index] & (tag_arr[index] == tag) & ~flush;

   assign mem_we  = 1'b0;
   assign mem_sel = '1;
   assign mem_adr = fill_adr;

   // Next-state and bus outputs.
   always_comb begin
      state_nxt  = state;
      cpu_ack    = 1'b0;
      cpu_err    = 1'b0;
      cpu_dat_s  = '0;
      mem_cyc    = 1'b0;
      mem_stb    = 1'b0;
      hit_inc    = 1'b0;
      miss_inc   = 1'b0;
      fill_done  = 1'b0;
      start_fill = 1'b0;
      case (state)
         IDLE: begin
            if (wreq) begin
               cpu_err = 1'b1;
            end else if (req && hit) begin
               cpu_ack   = 1'b1;
               cpu_dat_s = data_arr[index];
               hit_inc   = 1'b1;
            end else if (req) begin
               miss_inc   = 1'b1;
               start_fill = 1'b1;
               state_nxt  = FILL;
            end
         end
         FILL: begin
            // The fill runs to completion regardless of what the CPU does.
            mem_cyc = 1'b1;
            mem_stb = 1'b1;
            if (mem_ack) begin
               fill_done = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register and fill-address latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         fill_adr <= '0;
      end else begin
         state <= state_nxt;
         if (start_fill)
            fill_adr <= cpu_adr;
      end
   end

   // Valid bits: flush wins over a line being installed in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         valid <= '0;
      else if (flush)
         valid <= '0;
      else if (fill_done)
         valid[fill_index] <= 1'b1;
   end

   // Data and tag storage, written only when a fill completes; not reset.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         data_arr[fill_index] <= mem_dat_s;
         tag_arr[fill_index]  <= fill_tag;
      end
   end

   sat_counter #(.WIDTH(CNT_BITS)) u_hit_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (hit_inc),
      .count (hit_count)
   );

   sat_counter #(.WIDTH(CNT_BITS)) u_miss_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (miss_inc),
      .count (miss_count)
   );

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed scenarios plus randomized fetch traffic,
// checked against a resident-line model of a direct-mapped cache.
module tb_icache_dm;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cpu_cyc, cpu_stb, cpu_we;
   logic [11:0]   cpu_adr;
   logic [127:0]  cpu_dat_s;
   logic          cpu_ack, cpu_err;
   logic          mem_cyc, mem_stb, mem_we;
   logic [15:0]   mem_sel;
   logic [11:0]   mem_adr;
   logic [127:0]  mem_dat_s;
   logic          mem_ack;
   logic          flush;
   logic [15:0]   hit_count, miss_count;

   icache_dm dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_cyc    (cpu_cyc),
      .cpu_stb    (cpu_stb),
      .cpu_we     (cpu_we),
      .cpu_adr    (cpu_adr),
      .cpu_dat_s  (cpu_dat_s),
      .cpu_ack    (cpu_ack),
      .cpu_err    (cpu_err),
      .mem_cyc    (mem_cyc),
      .mem_stb    (mem_stb),
      .mem_we     (mem_we),
      .mem_sel    (mem_sel),
      .mem_adr    (mem_adr),
      .mem_dat_s  (mem_dat_s),
      .mem_ack    (mem_ack),
      .flush      (flush),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: which line address sits in each slot (-1 = empty) and its data.
   int           resident [8];
   logic [127:0] line_data [8];
   int           exp_hit, exp_miss;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 8; i++) resident[i] = -1;
   endtask

   task automatic bus_idle();
      cpu_cyc = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0;
      flush = 1'b0; mem_ack = 1'b0;
   endtask

   task automatic chk_counts(input string name);
      chk({name, "_hits"},   hit_count,  exp_hit);
      chk({name, "_misses"}, miss_count, exp_miss);
   endtask

   // All tasks start just after a falling edge and end at the next one.
   task automatic fetch(input logic [11:0] a, input int lat, input bit flush_at_ack,
                        input bit use_d, input logic [127:0] d_in);
      logic [127:0] d;
      int idx;
      bit first;
      idx   = int'(a[2:0]);
      first = 1'b1;
      for (int tries = 0; tries < 3; tries++) begin
         cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0; cpu_adr = a; flush = 1'b0;
         #1;
         if (resident[idx] == int'(a)) begin
            chk("hit_ack",    cpu_ack,   1);
            chk("hit_data",   cpu_dat_s, line_data[idx]);
            chk("hit_memcyc", mem_cyc,   0);
            exp_hit = sat(exp_hit + 1);
            @(negedge clk);
            bus_idle();
            return;
         end
         chk("miss_ack", cpu_ack, 0);
         exp_miss = sat(exp_miss + 1);
         @(negedge clk);
         d = (use_d && first) ? d_in : {$urandom, $urandom, $urandom, $urandom};
         for (int c = 1; c <= lat; c++) begin
            // CPU wanders during the fill; the fill must not care.
            cpu_cyc   = 1'($urandom_range(0, 1));
            cpu_stb   = 1'($urandom_range(0, 1));
            cpu_adr   = 12'($urandom);
            mem_ack   = (c == lat);
            mem_dat_s = (c == lat) ? d : {$urandom, $urandom, $urandom, $urandom};
            flush     = (c == lat) && flush_at_ack && first;
            #1;
            chk("fill_cyc",   mem_cyc, 1);
            chk("fill_stb",   mem_stb, 1);
            chk("fill_adr",   mem_adr, a);
            chk("fill_noack", cpu_ack, 0);
            @(negedge clk);
         end
         mem_ack = 1'b0;
         line_data[idx] = d;
         if (flush_at_ack && first) model_clear();
         else resident[idx] = int'(a);
         flush = 1'b0;
         first = 1'b0;
      end
      bus_idle();
   endtask

   task automatic write_req(input logic [11:0] a);
      cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b1; cpu_adr = a;
      #1;
      chk("wr_err",    cpu_err, 1);
      chk("wr_ack",    cpu_ack, 0);
      chk("wr_memcyc", mem_cyc, 0);
      @(negedge clk);
      bus_idle();
      #1;
      chk("wr_after_memcyc", mem_cyc, 0);
      chk("wr_after_err",    cpu_err, 0);
      @(negedge clk);
   endtask

   task automatic flush_pulse();
      bus_idle();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      model_clear();
   endtask

   initial begin
      logic [11:0] a;
      int r;
      model_clear();
      for (int i = 0; i < 8; i++) line_data[i] = '0;
      exp_hit = 0; exp_miss = 0;
      bus_idle();
      cpu_adr = '0; mem_dat_s = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ack",    cpu_ack,   0);
      chk("rst_err",    cpu_err,   0);
      chk("rst_dat",    cpu_dat_s, 0);
      chk("rst_memcyc", mem_cyc,   0);
      chk("rst_memstb", mem_stb,   0);
      chk("rst_memwe",  mem_we,    0);
      chk("rst_memsel", mem_sel,   16'hFFFF);
      chk("rst_memadr", mem_adr,   0);
      chk_counts("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // Cold miss, then hit on the same line.
      fetch(12'h030, 3, 1'b0, 1'b1, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_0001);
      chk_counts("cold");
      fetch(12'h030, 1, 1'b0, 1'b0, '0);
      chk_counts("hit");

      // Conflict eviction on index 0.
      fetch(12'h038, 2, 1'b0, 1'b0, '0);
      fetch(12'h030, 2, 1'b0, 1'b0, '0);
      chk_counts("conflict");

      // Flush racing a fill completion; everything must miss afterwards.
      fetch(12'h041, 2, 1'b1, 1'b0, '0);
      fetch(12'h030, 1, 1'b0, 1'b0, '0);
      chk_counts("flush");

      // Write requests are refused.
      write_req(12'h010);
      chk_counts("write");

      // Random traffic.
      for (int n = 0; n < 300; n++) begin
         r = int'($urandom_range(0, 11));
         if (r == 0)      flush_pulse();
         else if (r == 1) write_req(12'($urandom));
         else             fetch(12'($urandom_range(0, 31)), int'($urandom_range(1, 4)), 1'b0, 1'b0, '0);
         if (n % 50 == 49) chk_counts("random");
      end

      // Reset while a fill is outstanding.
      flush_pulse();
      cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0; cpu_adr = 12'h0A5;
      @(negedge clk);
      exp_miss = sat(exp_miss + 1);
      #1;
      chk("prerst_memstb", mem_stb, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_memstb", mem_stb, 0);
      chk("rst_async_memcyc", mem_cyc, 0);
      model_clear();
      exp_hit = 0; exp_miss = 0;
      bus_idle();
      @(negedge clk);
      rst_n = 1'b1;
      chk_counts("midfill_rst");
      @(negedge clk);
      fetch(12'h0A5, 2, 1'b0, 1'b0, '0);
      chk_counts("after_rst");

      // Hit counter saturation.
      a = 12'h0A5;
      cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0; cpu_adr = a;
      repeat (65541) @(negedge clk);
      exp_hit = sat(exp_hit + 65541);
      bus_idle();
      #1;
      chk("sat_hits", hit_count, 16'hFFFF);
      chk_counts("sat");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the datapath fetch master and the shared memory arbiter.
- The CPU side is a wishbone slave carrying 128-bit lines addressed by line (PC[15:4]). The memory side is a wishbone master that fills one line per miss.
- Hits are returned combinationally, so the single-cycle fetch path used by the pipeline's PC load logic is preserved.
- Includes a flush input and saturating hit/miss counters for performance measurement.

Parameters:
- INDEX_BITS, 3: log2 of the number of lines. Default is 8 lines.
- ADDR_BITS, 12: line-address width on both wishbone sides.
- LINE_BITS, 128: line and data width.
- CNT_BITS, 16: width of each performance counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_cyc  in  1  CPU bus cycle valid.
- cpu_stb  in  1  CPU strobe.
- cpu_we  in  1  CPU write enable. Writes are not supported.
- cpu_adr  in  ADDR_BITS  CPU line address.
- cpu_dat_s  out  LINE_BITS  line returned to the CPU.
- cpu_ack  out  1  CPU acknowledge.
- cpu_err  out  1  error response to a write request.
- mem_cyc  out  1  memory cycle.
- mem_stb  out  1  memory strobe.
- mem_we  out  1  tied to 0.
- mem_sel  out  LINE_BITS/8  tied to all ones.
- mem_adr  out  ADDR_BITS  fill address.
- mem_dat_s  in  LINE_BITS  fill data.
- mem_ack  in  1  memory acknowledge.
- flush  in  1  invalidate all lines.
- hit_count  out  CNT_BITS  saturating count of hits.
- miss_count  out  CNT_BITS  saturating count of misses.

Behaviour:
- Address split:
  - index = cpu_adr[INDEX_BITS-1:0]
  - tag = cpu_adr[ADDR_BITS-1:INDEX_BITS]
- Storage: per-line data array, tag array and valid bit. The valid bits and counters reset to 0. The data and tag arrays are not reset.
- Reset values: all outputs 0, except mem_sel, which is all ones. State = IDLE.
- Request: req = cpu_cyc & cpu_stb & ~cpu_we.
- Hit: hit = valid[index] & (tag_array[index] == tag).
- IDLE state:
  - On req & hit: cpu_ack=1 in the same cycle and cpu_dat_s=data[index]. The hit counter increments at the clock edge.
  - On req & ~hit:
    - latch cpu_adr into fill_adr;
    - increment the miss counter;
    - go to FILL.
    - cpu_ack stays 0.
  - On cpu_cyc & cpu_stb & cpu_we: cpu_err=1 for that cycle. There is no state change and no ACK.
- FILL state:
  - mem_cyc=mem_stb=1 and mem_adr=fill_adr, held stable until mem_ack.
  - cpu_ack stays 0.
  - On mem_ack:
    - write mem_dat_s into the data array at fill_adr's index;
    - write fill_adr's tag into the tag array;
    - set that line's valid bit;
    - go to IDLE.
  - The retried lookup hits in the next cycle. Miss-to-ACK latency = memory latency + 1 cycle.
- Fill while the CPU address changes or cpu_cyc drops:
  - The fill is never aborted. It completes and installs the fill_adr line.
  - The following IDLE lookup uses whatever cpu_adr is present then.
- Flush:
  - Clears all valid bits in one cycle, with priority over a fill write completing in the same cycle. The filled line's data and tag are written but its valid bit stays 0.
  - While flush=1, hit is forced to 0.
  - A FILL in progress continues normally.
- Counters:
  - Each counter counts at most 1 per cycle. The miss counter counts only on the IDLE→FILL transition, never on the retry hit.
  - Both saturate at all ones and never wrap.
- Reset asserted mid-FILL:
  - State returns to IDLE and mem_cyc/mem_stb drop immediately, asynchronously.
  - Valid bits clear, so no partial line ever becomes valid.

Decomposition:
- Shared package (extend lc3b_types):
  - lc3b_line;
  - lc3b_line_addr, 12 bits;
  - icache_state_t enum {IDLE, FILL}.
- Sub-module: sat_counter (parameterised width, inc, rst_n). Instantiate it twice, for the hit and miss counters.
- Storage arrays and the FSM stay in icache_dm.

Test Plan:
- Cold miss:
  - Stimulus: after reset, request cpu_adr=12'h030; memory ACKs after 3 cycles with 128'hAAAA...0001.
  - Required: mem_adr=12'h030 held for 3 cycles; cpu_ack 4 cycles after the request with the same data; hit_count=1, miss_count=1.
- Hit path: re-request 12'h030 → cpu_ack in the same cycle; mem_cyc stays 0; hit_count=2.
- Conflict eviction:
  - Stimulus: request 12'h038 (index 0, different tag), then 12'h030.
  - Required: each one misses and refills; miss_count increments by 2.
- Flush:
  - Stimulus: flush=1 in the same cycle that mem_ack completes the 12'h041 fill.
  - Required: the next request to 12'h041 misses again; every previously cached line also misses.
- Write request: cpu_we=1, cpu_adr=12'h010 → cpu_err=1 that cycle; no cpu_ack; no memory cycle; counters unchanged.
- Reset mid-fill:
  - Stimulus: drive rst_n=0 while in FILL.
  - Required: mem_stb drops without waiting for a clock edge. After release, request the same address → it misses again.
- Saturation: force 2^16+5 hits → hit_count=16'hFFFF.
